pci_bus_arbiter: RTL and testbench

// - Round-robin arbiter for the shared 16-bit PCI-style bus. It feeds the per-agent grant lines
//   (gntR to RAM, plus the DMA and 8085 grants) and consumes their request lines (reqR etc.).
// - Grants the bus to at most one agent at a time and holds the grant while that agent's request stays high.
// - Inserts one turnaround cycle between owners so that bus drivers never overlap.

---
 rtl/pci_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
//   Round-robin arbiter for the shared 16-bit PCI-style bus. At most one agent
//   owns the bus at a time. The owner keeps the grant for as long as it holds
//   its request high. There is always one turnaround cycle with no grant between
//   two owners, so the bus drivers of consecutive owners never overlap.
//
//   Agent index: 0 = 8085, 1 = DMA, 2 = RAM, 3 = spare.
//
//   Ports
//     clk       in   system clock; all logic runs on posedge
//     rst_n     in   synchronous, active-low reset
//     req       in   level request per agent
//     gnt       out  registered one-hot grant; all-zero when the bus has no owner
//     gnt_id    out  index of the current owner; valid only while gnt != 0
//     bus_idle  out  1 when the bus has no owner (IDLE or TURN)
//     preempt   out  one-cycle pulse when an owner is forcibly removed
//
//   Build option
//     ARB_TIMEOUT_EN  limits tenure to MAX_HOLD cycles while other agents
//                     are waiting. When this macro is undefined, preempt is
//                     tied to 0 and tenure is unlimited.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no owner and no turnaround in progress; arbitrate on req
//   GRANT    | gnt/gnt_id name the owner; leave when the owner drops req
//   TURN     | single gnt-low cycle between owners; arbitrate on req

module pci_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       bus_idle,
    output logic                       preempt
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;
    logic          drop_owner;

    // The search starts just after the previous winner, so the agent that
    // most recently owned the bus is considered last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int          CW      = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt;
    logic          timeout_hit;

    // Preemption happens only when some other agent is waiting. A lone owner
    // keeps the bus, and cnt stays saturated at CNT_MAX.
    assign timeout_hit = (state == ST_GRANT) && req[gnt_id] && (cnt == CNT_MAX)
                         && ((req & ~gnt) != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= timeout_hit;
            if (state != ST_GRANT) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
    assign preempt     = 1'b0;
`endif

    assign drop_owner = !req[gnt_id] || timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            bus_idle <= 1'b1;
            last     <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE, ST_TURN: begin
                    if (found) begin
                        state    <= ST_GRANT;
                        gnt      <= NUM_REQ'(1) << win;
                        gnt_id   <= win;
                        last     <= win;
                        bus_idle <= 1'b0;
                    end else begin
                        state    <= ST_IDLE;
                        gnt      <= '0;
                        bus_idle <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // gnt_id is left as it is so that it still names the
                    // last owner while the bus has no owner.
                    if (drop_owner) begin
                        state    <= ST_TURN;
                        gnt      <= '0;
                        bus_idle <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt      <= '0;
                    bus_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
module tb_pci_bus_arbiter;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       idle;
        logic       pre;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       idle;
        logic       pre;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       bus_idle;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    exp_t exp_q[$];

    pci_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .bus_idle (bus_idle),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic check_one(input string tag, input string what,
                             input logic [3:0] act, input logic [3:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s %s: got %b expected %b", tag, what, act, req_v);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e = exp_q.pop_front();
        check_one(e.tag, "gnt", gnt, e.gnt);
        check_one(e.tag, "gnt_id", {2'b00, gnt_id}, {2'b00, e.id});
        check_one(e.tag, "bus_idle", {3'b000, bus_idle}, {3'b000, e.idle});
        check_one(e.tag, "preempt", {3'b000, preempt}, {3'b000, e.pre});
        check_one(e.tag, "onehot0", {3'b000, $onehot0(gnt)}, 4'b0001);
    endtask

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] eid,
                        input logic eidle, input logic epre, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        e.gnt = eg; e.id = eid; e.idle = eidle; e.pre = epre; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        req   = 4'b0000;

        // reset with all requests pending, then the round-robin order 0,1,2,3,0
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1101, 4'b0000, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1011, 4'b0000, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0111, 4'b0000, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0});
        // lone requester 2 held for 5 cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0});
        // reset strikes mid-grant; the search restarts at index 0
        tbl.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0});
        // hand-over 1 -> 2, then 2 drops while 0 rises
        tbl.push_back('{1'b1, 4'b0100, 4'b0000, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0000, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0});
        // lone owner re-requests during TURN
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0});
        // simultaneous requests from IDLE: agent 3 wins because 0 was last
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1011, 4'b1000, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0011, 4'b0000, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].rst_n, tbl[i].req, tbl[i].gnt, tbl[i].id,
                 tbl[i].idle, tbl[i].pre, $sformatf("vec%0d", i));

        // owner 1 holds its request while agent 3 is waiting
        step(1'b0, 4'b1010, 4'b0000, 2'd0, 1'b1, 1'b0, "hold_rst");
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b0, $sformatf("hold%0d", i));
`ifdef ARB_TIMEOUT_EN
        step(1'b1, 4'b1010, 4'b0000, 2'd1, 1'b1, 1'b1, "preempt");
        step(1'b1, 4'b1010, 4'b1000, 2'd3, 1'b0, 1'b0, "after_preempt");
`else
        for (int i = 16; i < 40; i++)
            step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b0, $sformatf("hold%0d", i));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
